// File: rtl/lsu_rsp.sv
// Load/store response stage: aligns SRAM read data and returns it on a ready/valid writeback port.
// Define LSU_RSP_LLBIT_EN to include the LL bit register; without it llbit is tied low.
module lsu_rsp (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  load_op,
    input  logic [2:0]  store_op,
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  dest,
    input  logic [31:0] data_sram_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_dest,
    output logic        rsp_we,
    input  logic        llbit_clr,
    output logic        llbit
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [5:0]  op_q;
    logic        st_q;
    logic [1:0]  addr_q;
    logic [4:0]  dest_q;
    logic [31:0] hold_q;
    logic [31:0] aligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        accept;
    logic        handshake;
    logic        is_load;

    // op_q bits: [5] ld_b, [4] ld_h, [3] ld_w, [2] ld_bu, [1] ld_hu, [0] ll_w
    assign is_load   = (|op_q) & ~st_q;
    assign rsp_valid = resetn & (state != IDLE);
    assign handshake = rsp_valid & rsp_ready;
    assign req_ready = (state == IDLE) | handshake;
    assign accept    = req_valid & req_ready;
    assign rsp_data  = (state == HOLD) ? hold_q : aligned;
    assign rsp_dest  = dest_q;
    assign rsp_we    = is_load;

    always_comb begin
        byte_sel = data_sram_rdata[{addr_q, 3'b000} +: 8];
        half_sel = addr_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        aligned  = 32'h0;
        if (is_load) begin
            if (op_q[5])      aligned = {{24{byte_sel[7]}}, byte_sel};
            else if (op_q[4]) aligned = {{16{half_sel[15]}}, half_sel};
            else if (op_q[3]) aligned = data_sram_rdata;
            else if (op_q[2]) aligned = {24'h0, byte_sel};
            else if (op_q[1]) aligned = {16'h0, half_sel};
            else              aligned = data_sram_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = WAIT;
            WAIT, HOLD: begin
                if (rsp_ready) state_nxt = accept ? WAIT : IDLE;
                else           state_nxt = HOLD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            op_q   <= 6'h0;
            st_q   <= 1'b0;
            addr_q <= 2'h0;
            dest_q <= 5'h0;
            hold_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= load_op;
                st_q   <= |store_op;
                addr_q <= addr_lo;
                dest_q <= dest;
            end
            // SRAM data is only present for one cycle; keep it if writeback stalls
            if (state == WAIT && !rsp_ready) hold_q <= aligned;
        end
    end

`ifdef LSU_RSP_LLBIT_EN
    logic llbit_q;
    logic is_ll;

    assign is_ll = is_load & (op_q[5:1] == 5'h0);
    assign llbit = llbit_q;

    always_ff @(posedge clk) begin
        if (!resetn)                  llbit_q <= 1'b0;
        else if (llbit_clr)           llbit_q <= 1'b0;
        else if (handshake && is_ll)  llbit_q <= 1'b1;
    end
`else
    logic unused_llbit_clr;

    assign unused_llbit_clr = llbit_clr;
    assign llbit            = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_rsp.sv
// Scoreboard bench for lsu_rsp: directed vectors followed by randomized traffic and stalls.
`timescale 1ns/1ps
module tb_lsu_rsp;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  load_op = '0;
    logic [2:0]  store_op = '0;
    logic [1:0]  addr_lo = '0;
    logic [4:0]  dest = '0;
    logic [31:0] data_sram_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_dest;
    logic        rsp_we;
    logic        llbit_clr = 1'b0;
    logic        llbit;

    always #5 clk = ~clk;

    lsu_rsp dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .load_op(load_op), .store_op(store_op), .addr_lo(addr_lo), .dest(dest),
        .data_sram_rdata(data_sram_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_dest(rsp_dest), .rsp_we(rsp_we),
        .llbit_clr(llbit_clr), .llbit(llbit)
    );

`ifdef LSU_RSP_LLBIT_EN
    localparam logic LlEn = 1'b1;
`else
    localparam logic LlEn = 1'b0;
`endif

    localparam logic [5:0] LD_B = 6'b100000, LD_H = 6'b010000, LD_W = 6'b001000;
    localparam logic [5:0] LD_BU = 6'b000100, LD_HU = 6'b000010, LL_W = 6'b000001;

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic [4:0]  dest;
        logic        ll;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: first set load bit in priority order selects the extraction rule
    function automatic exp_t model(input logic [5:0] lop, input logic [2:0] sop,
                                   input logic [1:0] a, input logic [4:0] d,
                                   input logic [31:0] rd);
        exp_t        e;
        logic [7:0]  b;
        logic [15:0] h;
        b      = 8'(rd >> (8 * int'(a)));
        h      = a[1] ? rd[31:16] : rd[15:0];
        e.we   = (lop != 6'h0) && (sop == 3'h0);
        e.dest = d;
        e.ll   = (lop == LL_W) && (sop == 3'h0);
        e.data = 32'h0;
        if (e.we) begin
            if (lop[5])      e.data = 32'($signed(b));
            else if (lop[4]) e.data = 32'($signed(h));
            else if (lop[3]) e.data = rd;
            else if (lop[2]) e.data = 32'(b);
            else if (lop[1]) e.data = 32'(h);
            else             e.data = rd;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [5:0] lop, input logic [2:0] sop,
                         input logic [1:0] a, input logic [4:0] d, input logic [31:0] rd,
                         input logic rr, input logic clr, input logic [31:0] filler);
        @(posedge clk);
        #1;
        data_sram_rdata = pend ? pend_rdata : filler;
        req_valid = v;
        load_op   = lop;
        store_op  = sop;
        addr_lo   = a;
        dest      = d;
        rsp_ready = rr;
        llbit_clr = clr;
        @(negedge clk);
        if (req_valid && req_ready) begin
            sb.push_back(model(lop, sop, a, d, rd));
            pend       = 1'b1;
            pend_rdata = rd;
        end else begin
            pend = 1'b0;
        end
    endtask

    task automatic idle(input logic rr, input logic clr);
        drive(1'b0, 6'h0, 3'h0, 2'h0, 5'h0, 32'h0, rr, clr, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn    = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        llbit_clr = 1'b0;
        @(negedge clk);
        sb.delete();
        pend = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_llbit", 32'(llbit), 32'h0);
    endtask

    initial begin : monitor
        logic        ll_exp;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        hs;
        logic        is_ll;
        exp_t        e;
        ll_exp     = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            hs    = 1'b0;
            is_ll = 1'b0;
            chk("llbit", 32'(llbit), 32'(ll_exp));
            if (resetn) begin
                if (prev_stall && rsp_valid) chk("hold_stable", rsp_data, prev_data);
                if (rsp_valid && rsp_ready) begin
                    hs = 1'b1;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got data 0x%08h, expected no response",
                                 rsp_data);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_we", 32'(rsp_we), 32'(e.we));
                        chk("rsp_dest", 32'(rsp_dest), 32'(e.dest));
                        is_ll = e.ll;
                    end
                end
            end
            prev_stall = resetn && rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            if (!resetn)                   ll_exp = 1'b0;
            else if (llbit_clr)            ll_exp = 1'b0;
            else if (hs && is_ll && LlEn)  ll_exp = 1'b1;
        end
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("init_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("init_req_ready", 32'(req_ready), 32'h1);
        chk("init_llbit", 32'(llbit), 32'h0);

        // Signed byte at lane 3
        drive(1'b1, LD_B, 3'h0, 2'd3, 5'd5, 32'h80FF_1234, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b0);
        chk("ldb_valid", 32'(rsp_valid), 32'h1);
        chk("ldb_data", rsp_data, 32'hFFFF_FF80);
        chk("ldb_we", 32'(rsp_we), 32'h1);

        // Unsigned upper half held through a 3-cycle stall while SRAM data goes to 0
        drive(1'b1, LD_HU, 3'h0, 2'd2, 5'd7, 32'h9ABC_5678, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, LD_W, 3'h0, 2'd0, 5'd1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
            chk("stall_data", rsp_data, 32'h0000_9ABC);
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            chk("stall_valid", 32'(rsp_valid), 32'h1);
        end
        idle(1'b1, 1'b0);
        chk("stall_release", rsp_data, 32'h0000_9ABC);

        // Back-to-back
        drive(1'b1, LD_W, 3'h0, 2'd0, 5'd3, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        drive(1'b1, LD_BU, 3'h0, 2'd1, 5'd4, 32'h0000_AB00, 1'b1, 1'b0, 32'h0);
        chk("b2b_first", rsp_data, 32'h1111_1111);
        chk("b2b_req_ready", 32'(req_ready), 32'h1);
        idle(1'b1, 1'b0);
        chk("b2b_second", rsp_data, 32'h0000_00AB);

        // Store then signed half
        drive(1'b1, 6'h0, 3'b001, 2'd0, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        drive(1'b1, LD_H, 3'h0, 2'd0, 5'd10, 32'h0000_8001, 1'b1, 1'b0, 32'h0);
        chk("st_we", 32'(rsp_we), 32'h0);
        chk("st_data", rsp_data, 32'h0);
        idle(1'b1, 1'b0);
        chk("ldh_data", rsp_data, 32'hFFFF_8001);

        // LL bit set, then cleared by a pulse on the second ll_w handshake
        drive(1'b1, LL_W, 3'h0, 2'd0, 5'd11, 32'hCAFE_0001, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("ll_set", 32'(llbit), 32'(LlEn));
        drive(1'b1, LL_W, 3'h0, 2'd0, 5'd12, 32'hCAFE_0002, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        chk("ll_clr_wins", 32'(llbit), 32'h0);

        // Reset while holding a response with llbit set
        drive(1'b1, LL_W, 3'h0, 2'd0, 5'd13, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0);
        drive(1'b1, LD_W, 3'h0, 2'd0, 5'd14, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            int         k;
            logic [5:0] lop;
            logic [2:0] sop;
            k   = int'($urandom_range(0, 8));
            lop = 6'h0;
            sop = 3'h0;
            if (k < 6)       lop = 6'(1 << k);
            else if (k == 6) lop = 6'($urandom_range(1, 63));
            else if (k == 7) sop = 3'(1 << $urandom_range(0, 2));
            drive($urandom_range(0, 3) != 0, lop, sop, 2'($urandom), 5'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom);
        end

        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0 && !pend) break;
            idle(1'b1, 1'b0);
        end
        chk("drain_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
